run_step_ctrl: RTL and testbench

Run/halt/single-step sequencer for the board-level computer. Sits between the board buttons/switches and the `comp` instance, next to the clock mux. Generates a clock-enable (`cpu_ce`) and a reset request (`cpu_reset`) for the computer, so the design can run, halt, single-step or burst-step on the fixed selected clock without switching clocks.

---
 rtl/run_step_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_run_step_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_step_ctrl.sv
// Run/halt/single-step/burst sequencer: debounces the board buttons and drives cpu_ce / cpu_reset.
// Optional breakpoint halt is compiled in when RUN_STEP_CTRL_BRK_EN is defined.
module run_step_ctrl #(
  parameter int DEB_TICKS  = 4,
  parameter int BURST_LEN  = 16,
  parameter int RST_CYCLES = 8,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [3:0]        btn,
  input  logic [3:0]        rate_sel,
  input  logic              brk_en,
  input  logic [ADDR_W-1:0] brk_addr,
  input  logic [ADDR_W-1:0] addr,
  output logic              cpu_ce,
  output logic              cpu_reset,
  output logic              running,
  output logic [2:0]        state,
  output logic [31:0]       ce_cnt,
  output logic              brk_hit
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_HALT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_BURST = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       lvl_q, lvl_d;
  logic [3:0][3:0]  deb_q, deb_d;
  logic [15:0]      div_q, div_d;
  logic [15:0]      burst_q, burst_d;
  logic [7:0]       rst_q, rst_d;
  logic [31:0]      ce_cnt_q, ce_cnt_d;
  logic             brk_q, brk_d;
  logic             cpu_reset_q, running_q;
  logic [3:0]       press_s, act_s;
  logic [15:0]      mask_s;
  logic             ce_s, brk_fire_s;

  // Debounce each button; a press is the tick on which the level flips 0->1
  always_comb begin
    lvl_d   = lvl_q;
    deb_d   = deb_q;
    press_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (tick) begin
        if (btn[i] != lvl_q[i]) begin
          if (deb_q[i] == 4'(DEB_TICKS - 1)) begin
            lvl_d[i]   = ~lvl_q[i];
            deb_d[i]   = 4'd0;
            press_s[i] = ~lvl_q[i];
          end else begin
            deb_d[i] = deb_q[i] + 4'd1;
          end
        end else begin
          deb_d[i] = 4'd0;
        end
      end else begin
        deb_d[i] = deb_q[i];
      end
    end
  end

  // Keep only the highest-priority press: reset > run/halt > burst > step
  always_comb begin
    if (press_s[3]) begin
      act_s = 4'b1000;
    end else if (press_s[0]) begin
      act_s = 4'b0001;
    end else if (press_s[2]) begin
      act_s = 4'b0100;
    end else if (press_s[1]) begin
      act_s = 4'b0010;
    end else begin
      act_s = 4'b0000;
    end
  end

  // Clock-enable decode; rate_sel is used live so a rate change applies at once
  always_comb begin
    mask_s = ~(16'hFFFF << rate_sel);
    case (state_q)
      ST_RUN:   ce_s = ((div_q & mask_s) == mask_s);
      ST_STEP:  ce_s = 1'b1;
      ST_BURST: ce_s = 1'b1;
      default:  ce_s = 1'b0;
    endcase
  end

`ifdef RUN_STEP_CTRL_BRK_EN
  // Breakpoint: the matching cpu_ce cycle is issued, then the sequencer halts
  always_comb begin
    if ((state_q == ST_RUN) || (state_q == ST_BURST)) begin
      brk_fire_s = brk_en & ce_s & (addr == brk_addr);
    end else begin
      brk_fire_s = 1'b0;
    end
  end
`else
  logic unused_brk_s;
  assign unused_brk_s = ^{brk_en, brk_addr, addr};
  assign brk_fire_s   = 1'b0;
`endif

  // Next-state logic for the sequencer and its counters
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    burst_d  = burst_q;
    rst_d    = rst_q;
    brk_d    = brk_q;
    ce_cnt_d = ce_cnt_q + {31'd0, ce_s};
    if (act_s[3]) begin
      state_d  = ST_RST;
      rst_d    = 8'd0;
      ce_cnt_d = 32'd0;
      brk_d    = 1'b0;
    end else begin
      case (state_q)
        ST_RST: begin
          if (rst_q == 8'(RST_CYCLES - 1)) begin
            state_d = ST_HALT;
            rst_d   = 8'd0;
          end else begin
            rst_d = rst_q + 8'd1;
          end
        end
        ST_HALT: begin
          if (act_s != 4'b0000) begin
            brk_d = 1'b0;
          end else begin
            brk_d = brk_q;
          end
          if (act_s[0]) begin
            state_d = ST_RUN;
            div_d   = 16'd0;
          end else if (act_s[1]) begin
            state_d = ST_STEP;
          end else if (act_s[2]) begin
            state_d = ST_BURST;
            burst_d = 16'(BURST_LEN);
          end else begin
            state_d = ST_HALT;
          end
        end
        ST_RUN: begin
          div_d = div_q + 16'd1;
          if (brk_fire_s) begin
            state_d = ST_HALT;
            brk_d   = 1'b1;
          end else if (act_s[0]) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_STEP: begin
          state_d = ST_HALT;
        end
        ST_BURST: begin
          burst_d = burst_q - 16'd1;
          if (brk_fire_s) begin
            state_d = ST_HALT;
            brk_d   = 1'b1;
          end else if (act_s[0] || (burst_q == 16'd1)) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_BURST;
          end
        end
        default: begin
          state_d = ST_RST;
          rst_d   = 8'd0;
        end
      endcase
    end
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RST;
      lvl_q       <= 4'b0000;
      deb_q       <= '0;
      div_q       <= 16'd0;
      burst_q     <= 16'd0;
      rst_q       <= 8'd0;
      ce_cnt_q    <= 32'd0;
      brk_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      deb_q       <= deb_d;
      div_q       <= div_d;
      burst_q     <= burst_d;
      rst_q       <= rst_d;
      ce_cnt_q    <= ce_cnt_d;
      brk_q       <= brk_d;
      cpu_reset_q <= (state_d == ST_RST);
      running_q   <= (state_d == ST_RUN);
    end
  end

  assign cpu_ce    = ce_s;
  assign cpu_reset = cpu_reset_q;
  assign running   = running_q;
  assign state     = state_q;
  assign ce_cnt    = ce_cnt_q;
  assign brk_hit   = brk_q;

endmodule

// File: tb/tb_run_step_ctrl.sv
// Bench for run_step_ctrl: directed button scenarios plus a random phase, all checked every clock
// against a behavioural model of the sequencer rules.
module tb_run_step_ctrl;
  localparam int DEB = 4;
  localparam int BL  = 16;
  localparam int RC  = 8;
  localparam int AW  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [3:0]    btn;
  logic [3:0]    rate_sel;
  logic          brk_en;
  logic [AW-1:0] brk_addr;
  logic [AW-1:0] addr;
  logic          cpu_ce, cpu_reset, running, brk_hit;
  logic [2:0]    state;
  logic [31:0]   ce_cnt;

  int vectors = 0, miscompares = 0, ce_seen = 0, rst_seen = 0;

  // model: mode 0=RST 1=HALT 2=RUN 3=STEP 4=BURST
  int          m_mode, m_div, m_burst, m_rst;
  int          m_lvl[4], m_cnt[4];
  logic [31:0] m_ce_cnt;
  bit          m_brk;

  run_step_ctrl #(.DEB_TICKS(DEB), .BURST_LEN(BL), .RST_CYCLES(RC), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn(btn), .rate_sel(rate_sel),
    .brk_en(brk_en), .brk_addr(brk_addr), .addr(addr),
    .cpu_ce(cpu_ce), .cpu_reset(cpu_reset), .running(running), .state(state),
    .ce_cnt(ce_cnt), .brk_hit(brk_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ce();
    int period;
    period = 1 << rate_sel;
    if (m_mode == 2) return (m_div % period) == period - 1;
    return (m_mode == 3) || (m_mode == 4);
  endfunction

  function automatic bit model_brk(input bit ce);
`ifdef RUN_STEP_CTRL_BRK_EN
    return brk_en && ce && (addr == brk_addr);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_div = 0; m_burst = 0; m_rst = 0; m_ce_cnt = 0; m_brk = 0;
    for (int i = 0; i < 4; i++) begin m_lvl[i] = 0; m_cnt[i] = 0; end
  endtask

  task automatic model_advance();
    bit press[4];
    bit ce;
    int pk;
    ce = model_ce();
    for (int i = 0; i < 4; i++) begin
      press[i] = 0;
      if (tick) begin
        if (int'(btn[i]) != m_lvl[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB) begin
            m_lvl[i] = 1 - m_lvl[i];
            m_cnt[i] = 0;
            press[i] = (m_lvl[i] == 1);
          end
        end else m_cnt[i] = 0;
      end
    end
    pk = press[3] ? 3 : press[0] ? 0 : press[2] ? 2 : press[1] ? 1 : -1;
    if (ce) m_ce_cnt++;
    if (pk == 3) begin
      m_mode = 0; m_rst = 0; m_ce_cnt = 0; m_brk = 0;
    end else if (m_mode == 0) begin
      if (m_rst == RC - 1) begin m_mode = 1; m_rst = 0; end
      else m_rst++;
    end else if (m_mode == 1) begin
      if (pk >= 0) m_brk = 0;
      if (pk == 0) begin m_mode = 2; m_div = 0; end
      else if (pk == 1) m_mode = 3;
      else if (pk == 2) begin m_mode = 4; m_burst = BL; end
    end else if (m_mode == 2) begin
      m_div = (m_div + 1) % 65536;
      if (model_brk(ce)) begin m_mode = 1; m_brk = 1; end
      else if (pk == 0) m_mode = 1;
    end else if (m_mode == 3) begin
      m_mode = 1;
    end else begin
      if (model_brk(ce)) begin m_mode = 1; m_brk = 1; end
      else if (pk == 0 || m_burst == 1) m_mode = 1;
      else m_burst--;
    end
  endtask

  task automatic check_outputs();
    check("state", {29'd0, state}, m_mode);
    check("running", {31'd0, running}, (m_mode == 2) ? 1 : 0);
    check("cpu_reset", {31'd0, cpu_reset}, (m_mode == 0) ? 1 : 0);
    check("cpu_ce", {31'd0, cpu_ce}, {31'd0, model_ce()});
    check("ce_cnt", ce_cnt, m_ce_cnt);
    check("brk_hit", {31'd0, brk_hit}, {31'd0, m_brk});
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (cpu_ce === 1'b1) ce_seen++;
    if (cpu_reset === 1'b1) rst_seen++;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic hold(input logic [3:0] pat, input int n);
    btn = pat;
    cycles(n);
    btn = 4'b0000;
  endtask

  initial begin
    reset = 1'b0; tick = 1'b1; btn = 4'b0000; rate_sel = 4'd2;
    brk_en = 1'b0; brk_addr = 16'h0010; addr = 16'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1 reset = 1'b1;

    // reset sequence: 8 clocks of cpu_reset then HALT
    rst_seen = 0;
    cycles(10);
    check("rst_len", rst_seen, 8);
    check("halt_after_rst", {29'd0, state}, 32'd1);

    // single step, then a glitch too short to debounce
    ce_seen = 0;
    hold(4'b0010, 4);
    cycles(6);
    check("step_pulses", ce_seen, 1);
    check("step_ce_cnt", ce_cnt, 32'd1);
    ce_seen = 0;
    hold(4'b0010, 3);
    cycles(6);
    check("glitch_pulses", ce_seen, 0);
    check("glitch_state", {29'd0, state}, 32'd1);

    // run at rate_sel=2, then halt
    rate_sel = 4'd2;
    hold(4'b0001, 4);
    ce_seen = 0;
    cycles(40);
    check("run_rate", ((ce_seen >= 9) && (ce_seen <= 11)) ? 1 : 0, 1);
    check("run_running", {31'd0, running}, 32'd1);
    hold(4'b0001, 4);
    cycles(6);
    ce_seen = 0;
    cycles(10);
    check("halt_no_ce", ce_seen, 0);

    // full burst, then a burst aborted by run/halt
    ce_seen = 0;
    hold(4'b0100, 4);
    cycles(25);
    check("burst_len", ce_seen, BL);
    check("burst_halt", {29'd0, state}, 32'd1);
    ce_seen = 0;
    hold(4'b0100, 4);
    cycle();
    hold(4'b0001, 4);
    cycles(8);
    check("burst_abort", ((ce_seen >= 5) && (ce_seen <= 6)) ? 1 : 0, 1);

    // reset and run/halt in the same tick while running: reset wins
    hold(4'b0001, 4);
    cycles(6);
    rst_seen = 0;
    hold(4'b1001, 4);
    cycles(12);
    check("rst_prio_len", rst_seen, 8);
    check("rst_prio_ce_cnt", ce_cnt, 32'd0);
    check("rst_prio_state", {29'd0, state}, 32'd1);

    // breakpoint on the 3rd cpu_ce of a run at full rate
    rate_sel = 4'd0;
    brk_en   = 1'b1;
    hold(4'b0001, 4);
    cycles(2);
    addr = 16'h0010;
    cycle();
    addr = 16'h0000;
    cycles(5);
`ifdef RUN_STEP_CTRL_BRK_EN
    check("brk_state", {29'd0, state}, 32'd1);
    check("brk_flag", {31'd0, brk_hit}, 32'd1);
    check("brk_ce_cnt", ce_cnt, 32'd3);
    hold(4'b0010, 4);
    cycles(6);
    check("brk_clear", {31'd0, brk_hit}, 32'd0);
    check("brk_step_ce_cnt", ce_cnt, 32'd4);
`else
    check("nobrk_flag", {31'd0, brk_hit}, 32'd0);
    check("nobrk_running", {31'd0, running}, 32'd1);
    hold(4'b0001, 4);
    cycles(6);
`endif

    // random phase
    for (int seg = 0; seg < 400; seg++) begin
      int r, len;
      r   = int'($urandom_range(0, 15));
      len = int'($urandom_range(1, 8));
      if (r < 6) btn = 4'b0000;
      else if (r < 8) btn = 4'b0001;
      else if (r < 10) btn = 4'b0010;
      else if (r < 12) btn = 4'b0100;
      else if (r < 13) btn = 4'b1000;
      else btn = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rate_sel = 4'($urandom_range(0, 3));
      brk_en = 1'($urandom_range(0, 1));
      addr   = 16'($urandom_range(14, 18));
      for (int k = 0; k < len; k++) begin
        tick = ($urandom_range(0, 3) != 0);
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
